// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle multiply/divide sequencer for the EX stage.
// The result is computed when the operation starts and held in RHI/RLO; it is
// copied to HI/LO only after the fixed latency, so it stays hidden until completion.
// It also owns mthi/mtlo writes and the ID-stage stall for HI/LO users.
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        MDStart,
    input  logic [1:0]  MDControl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        WrHI,
    input  logic        WrLO,
    input  logic        Flush,
    input  logic        UseMD_D,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

    state_t      state_reg;
    logic [5:0]  cnt_reg;
    logic [31:0] hi_reg, lo_reg;
    logic [31:0] rhi_reg, rlo_reg;

    logic        is_div, is_signed;
    logic [63:0] prod;
    logic [31:0] a_mag, b_mag, dividend, divisor;
    logic [31:0] q_mag, r_mag;
    logic [31:0] res_hi, res_lo;

    assign is_div    = MDControl[1];
    assign is_signed = ~MDControl[0];

    // Result of the operation presented on A/B/MDControl, captured at start.
    // Signed divide runs on magnitudes; 0x80000000 / -1 then falls out as
    // 0x80000000 remainder 0 because -(2^31) wraps back to itself.
    always_comb begin
        res_hi   = 32'h0;
        res_lo   = 32'h0;
        if (is_signed)
            prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        else
            prod = {32'h0, A} * {32'h0, B};
        a_mag    = A[31] ? -A : A;
        b_mag    = B[31] ? -B : B;
        dividend = is_signed ? a_mag : A;
        divisor  = is_signed ? b_mag : B;
        if (divisor == 32'h0)
            divisor = 32'h1;  // keep the divider defined; zero divisor handled below
        q_mag    = dividend / divisor;
        r_mag    = dividend % divisor;
        if (!is_div) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (B == 32'h0) begin
            res_hi = A;
            res_lo = 32'hFFFF_FFFF;
        end else if (is_signed) begin
            res_lo = (A[31] ^ B[31]) ? -q_mag : q_mag;
            res_hi = A[31] ? -r_mag : r_mag;
        end else begin
            res_lo = q_mag;
            res_hi = r_mag;
        end
    end

    // Sequencer: start/latency count/commit, plus mthi/mtlo writes when idle.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 6'd0;
            hi_reg    <= 32'h0;
            lo_reg    <= 32'h0;
            rhi_reg   <= 32'h0;
            rlo_reg   <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!Flush) begin
                        if (MDStart) begin
                            rhi_reg   <= res_hi;
                            rlo_reg   <= res_lo;
                            cnt_reg   <= is_div ? DIV_LOAD : MULT_LOAD;
                            state_reg <= RUN;
                        end else begin
                            if (WrHI) hi_reg <= A;
                            if (WrLO) lo_reg <= A;
                        end
                    end
                end
                RUN: begin
                    if (Flush) begin
                        // Abort wins even on the completion cycle.
                        state_reg <= IDLE;
                        cnt_reg   <= 6'd0;
                    end else if (cnt_reg == 6'd0) begin
                        hi_reg    <= rhi_reg;
                        lo_reg    <= rlo_reg;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 6'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign Busy  = (state_reg == RUN);
    assign Stall = UseMD_D & (Busy | MDStart) & ~Flush;
    assign HI    = hi_reg;
    assign LO    = lo_reg;

    // The ID-stage stall must keep new HI/LO requests away from a running unit.
    a_no_req_in_run: assert property (@(posedge CLK) disable iff (!reset)
        (state_reg == RUN) |-> !(MDStart || WrHI || WrLO));

endmodule

// File: tb/tb_md_ctrl.sv
module tb_md_ctrl;

    logic        CLK;
    logic        reset;
    logic        MDStart;
    logic [1:0]  MDControl;
    logic [31:0] A, B;
    logic        WrHI, WrLO, Flush, UseMD_D;
    logic        Busy, Stall;
    logic [31:0] HI, LO;

    int checks   = 0;
    int failures = 0;

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .CLK(CLK), .reset(reset), .MDStart(MDStart), .MDControl(MDControl),
        .A(A), .B(B), .WrHI(WrHI), .WrLO(WrLO), .Flush(Flush),
        .UseMD_D(UseMD_D), .Busy(Busy), .Stall(Stall), .HI(HI), .LO(LO)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Start one operation and follow it to completion, checking latency,
    // stall coverage, hidden result while busy, and final HI/LO.
    task automatic run_op(input logic [1:0] ctrl, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic use_md, input string name);
        logic [31:0] hi0, lo0;
        int busy_n, stall_n, exp_stall;
        bit early;
        hi0 = HI; lo0 = LO;
        busy_n = 0; stall_n = 0; early = 0;
        exp_stall = use_md ? n + 1 : 0;
        UseMD_D = use_md; MDControl = ctrl; A = a; B = b; MDStart = 1'b1;
        #1;
        if (Stall) stall_n++;
        tick();
        MDStart = 1'b0; A = 32'h0; B = 32'h0;
        while (Busy && busy_n < 64) begin
            busy_n++;
            if (Stall) stall_n++;
            if (HI !== hi0 || LO !== lo0) early = 1;
            tick();
        end
        checks++;
        if (busy_n !== n) begin
            failures++;
            $display("FAIL %s busy_cycles got=%0d exp=%0d", name, busy_n, n);
        end
        checks++;
        if (stall_n !== exp_stall) begin
            failures++;
            $display("FAIL %s stall_cycles got=%0d exp=%0d", name, stall_n, exp_stall);
        end
        checks++;
        if (early !== 1'b0) begin
            failures++;
            $display("FAIL %s hilo_changed_while_busy got=1 exp=0", name);
        end
        checks++;
        if (HI !== exp_hi) begin
            failures++;
            $display("FAIL %s HI got=%h exp=%h", name, HI, exp_hi);
        end
        checks++;
        if (LO !== exp_lo) begin
            failures++;
            $display("FAIL %s LO got=%h exp=%h", name, LO, exp_lo);
        end
        $display("%s: ctrl=%b a=%h b=%h busy=%0d stall=%0d HI=%h LO=%h",
                 name, ctrl, a, b, busy_n, stall_n, HI, LO);
        UseMD_D = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; MDStart = 0; MDControl = 0; A = 0; B = 0;
        WrHI = 0; WrLO = 0; Flush = 0; UseMD_D = 0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0 || Stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got busy=%b stall=%b HI=%h LO=%h exp 0 0 0 0",
                     Busy, Stall, HI, LO);
        end
        reset = 1'b1;
        tick();
        UseMD_D = 1'b1;
        #1;
        checks++;
        if (Stall !== 1'b0) begin
            failures++;
            $display("FAIL idle_use_no_stall got=%b exp=0", Stall);
        end
        UseMD_D = 1'b0;
        $display("reset: busy=%b HI=%h LO=%h", Busy, HI, LO);
        tick();
    endtask

    task automatic test_arith();
        run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1, "mult_neg");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg");
        run_op(2'b11, 32'd7, 32'd0, 10, 32'd7, 32'hFFFF_FFFF, 1'b0, "divu_zero");
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 10, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, "div_zero");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, 1'b0, "div_ovf");
        run_op(2'b11, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b1, "divu_basic");
    endtask

    task automatic test_back_to_back();
        // run_op returns in the cycle after Busy fell, so the next start is N+1 after the previous
        run_op(2'b00, 32'd6, 32'd7, 5, 32'h0, 32'd42, 1'b1, "b2b_first");
        run_op(2'b10, 32'd17, 32'hFFFF_FFFB, 10, 32'd2, 32'hFFFF_FFFD, 1'b1, "b2b_second");
    endtask

    task automatic test_flush();
        WrHI = 1; WrLO = 1; A = 32'h1234_5678;
        tick();
        WrHI = 0; WrLO = 0; A = 0;
        checks++;
        if (HI !== 32'h1234_5678 || LO !== 32'h1234_5678) begin
            failures++;
            $display("FAIL preload got HI=%h LO=%h exp 12345678", HI, LO);
        end
        // Flush in the 4th busy cycle of a divide
        UseMD_D = 1; MDControl = 2'b10; A = 32'd100; B = 32'd3; MDStart = 1;
        tick();
        MDStart = 0; A = 0; B = 0;
        repeat (3) tick();
        Flush = 1;
        #1;
        checks++;
        if (Busy !== 1'b1 || Stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_cycle got busy=%b stall=%b exp busy=1 stall=0", Busy, Stall);
        end
        tick();
        Flush = 0;
        checks++;
        if (Busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy_drop got=%b exp=0", Busy);
        end
        repeat (12) tick();
        checks++;
        if (HI !== 32'h1234_5678 || LO !== 32'h1234_5678) begin
            failures++;
            $display("FAIL flush_hilo got HI=%h LO=%h exp 12345678", HI, LO);
        end
        $display("flush_mid: busy=%b HI=%h LO=%h", Busy, HI, LO);
        // Flush on the completion cycle of a multiply
        MDControl = 2'b00; A = 32'd2; B = 32'd3; MDStart = 1;
        tick();
        MDStart = 0; A = 0; B = 0;
        repeat (4) tick();
        Flush = 1;
        tick();
        Flush = 0;
        checks++;
        if (Busy !== 1'b0 || HI !== 32'h1234_5678 || LO !== 32'h1234_5678) begin
            failures++;
            $display("FAIL flush_complete got busy=%b HI=%h LO=%h exp 0 12345678 12345678",
                     Busy, HI, LO);
        end
        $display("flush_complete: busy=%b HI=%h LO=%h", Busy, HI, LO);
        UseMD_D = 0;
    endtask

    task automatic test_start_priority();
        // MDStart together with WrHI/WrLO: the writes are dropped
        WrHI = 1; WrLO = 1; MDControl = 2'b00; A = 32'd5; B = 32'd6; MDStart = 1;
        tick();
        WrHI = 0; WrLO = 0; MDStart = 0; A = 0; B = 0;
        checks++;
        if (HI !== 32'h1234_5678 || LO !== 32'h1234_5678) begin
            failures++;
            $display("FAIL start_beats_write got HI=%h LO=%h exp 12345678", HI, LO);
        end
        for (int i = 0; i < 20 && Busy; i++) tick();
        checks++;
        if (HI !== 32'h0 || LO !== 32'd30) begin
            failures++;
            $display("FAIL start_write_result got HI=%h LO=%h exp 0 1e", HI, LO);
        end
        $display("start_priority: HI=%h LO=%h", HI, LO);
        // Flush with MDStart and writes in IDLE: everything suppressed
        UseMD_D = 1; Flush = 1; MDStart = 1; WrHI = 1; WrLO = 1; A = 32'd9; B = 32'd9;
        #1;
        checks++;
        if (Stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_start_stall got=%b exp=0", Stall);
        end
        tick();
        Flush = 0; MDStart = 0; WrHI = 0; WrLO = 0; A = 0; B = 0; UseMD_D = 0;
        checks++;
        if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'd30) begin
            failures++;
            $display("FAIL flush_start got busy=%b HI=%h LO=%h exp 0 0 1e", Busy, HI, LO);
        end
        $display("flush_start: busy=%b HI=%h LO=%h", Busy, HI, LO);
    endtask

    task automatic test_write_and_async_reset();
        WrHI = 1; WrLO = 1; A = 32'hDEAD_BEEF;
        tick();
        WrHI = 0; WrLO = 0; A = 0;
        checks++;
        if (HI !== 32'hDEAD_BEEF || LO !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL write_hilo got HI=%h LO=%h exp deadbeef", HI, LO);
        end
        $display("write_hilo: HI=%h LO=%h", HI, LO);
        MDControl = 2'b00; A = 32'd3; B = 32'd3; MDStart = 1;
        tick();
        MDStart = 0; A = 0; B = 0;
        tick();
        checks++;
        if (Busy !== 1'b1) begin
            failures++;
            $display("FAIL run_before_reset got busy=%b exp=1", Busy);
        end
        reset = 0;
        #1;
        checks++;
        if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            failures++;
            $display("FAIL async_reset got busy=%b HI=%h LO=%h exp 0 0 0", Busy, HI, LO);
        end
        tick();
        tick();
        reset = 1;
        repeat (10) tick();
        checks++;
        if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            failures++;
            $display("FAIL reset_no_pending got busy=%b HI=%h LO=%h exp 0 0 0", Busy, HI, LO);
        end
        $display("async_reset: busy=%b HI=%h LO=%h", Busy, HI, LO);
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_flush();
        test_start_priority();
        test_write_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multi-cycle multiply/divide sequencer for the P7 pipeline's EX stage. It accepts the MDStart/MDControl pair from the ID/EX pipeline register and runs a signed or unsigned multiply or divide for a fixed latency. It owns the HI/LO registers, services mthi/mtlo writes, and generates the ID-stage stall for any instruction that touches HI/LO while the unit is busy.

## Interface
Parameters:
- MULT_CYCLES, 5, Busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, Busy cycles for div/divu (≥1)

Ports:
- CLK  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- MDStart  in  1  start pulse from ID/EX register, one cycle per operation
- MDControl  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled with MDStart
- A  in  32  operand rs (forwarded V1)
- B  in  32  operand rt (forwarded V2)
- WrHI  in  1  mthi in EX: write A to HI
- WrLO  in  1  mtlo in EX: write A to LO
- Flush  in  1  exception/interrupt flush of EX; aborts the operation
- UseMD_D  in  1  instruction in ID is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- Busy  out  1  operation in progress
- Stall  out  1  freeze PC/IFID, NOP-clear IDEX
- HI  out  32  HI register
- LO  out  32  LO register

## Operation
- States: IDLE, RUN. 6-bit down-counter CNT. Result holding registers RHI/RLO.
- IDLE, MDStart=1, Flush=0:
  - Compute the result from A, B, MDControl and store it in RHI/RLO. Either compute at start or iterate in RUN; the result is visible only at completion.
  - Load CNT = (MULT_CYCLES or DIV_CYCLES) − 1 and go to RUN.
- RUN:
  - CNT≠0: CNT−1.
  - CNT=0: HI←RHI, LO←RLO, go to IDLE.
- Arithmetic:
  - mult/multu: 64-bit signed/unsigned product; HI = [63:32], LO = [31:0].
  - div/divu: LO = quotient (truncated toward zero), HI = remainder (sign of dividend).
- Boundary rules:
  - Divide by zero (div or divu): LO = 32'hFFFF_FFFF, HI = A.
  - div 32'h8000_0000 / 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0.
  - WrHI/WrLO in IDLE with MDStart=0: write at the edge. WrHI and WrLO may both be high and both write.
  - MDStart and WrHI/WrLO in the same cycle: MDStart wins; the writes are ignored.
  - MDStart, WrHI or WrLO while in RUN: ignored. The Stall rule prevents this case; it is checked by assertion.
  - Flush in RUN: go to IDLE immediately; HI/LO are not updated; RHI/RLO are discarded.
  - Flush with MDStart in IDLE: start suppressed; WrHI/WrLO are also suppressed.
  - Flush in the completion cycle (RUN, CNT=0): abort wins; HI/LO are unchanged.
- Busy = (state == RUN).
- Stall = UseMD_D & (Busy | MDStart) & ~Flush.

## Timing
- Reset (async, low): state=IDLE, CNT=0, HI=0, LO=0, RHI=RLO=0, Busy=0. Stall=0 whenever UseMD_D=0.
- Start sampled at edge E0: Busy=1 from E0 through edge E0+N, where N is the cycle count for the operation. Busy is high for exactly N cycles.
- HI/LO take the new value at edge E0+N, the same edge on which Busy falls.
- mfhi/mflo in ID is stalled until Busy=0, so it reads the new value in its EX cycle.
- Stall is combinational. It is high in the MDStart cycle and during all Busy cycles when UseMD_D=1.
- A back-to-back operation can start at the edge after Busy falls. Minimum spacing is N+1 cycles between MDStart pulses.
- Reset asserted during RUN: immediate return to IDLE, HI/LO=0, no pending write.

## Test plan
- Reset, then mult A=32'hFFFF_FFFE (−2), B=3 → Busy high 5 cycles; then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
- multu A=32'hFFFF_FFFF, B=32'hFFFF_FFFF → after 5 cycles HI=32'hFFFF_FFFE, LO=32'h0000_0001.
- div A=−7, B=2 → after 10 cycles LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. divu A=7, B=0 → LO=32'hFFFF_FFFF, HI=7.
- mult start with UseMD_D held high → Stall=1 for the start cycle plus 5 Busy cycles, then 0. Repeat with UseMD_D=0 → Stall stays 0.
- div start, Flush at cycle 4 → Busy drops the next edge; HI/LO keep their prior values (preload via WrHI/WrLO=32'h1234_5678).
- WrHI+WrLO with A=32'hDEAD_BEEF in IDLE → HI=LO=32'hDEAD_BEEF. Then assert reset mid-RUN → Busy=0 and HI=LO=0 immediately, with no clock edge required.
